// File: rtl/sram_2_16_scn4m_subm.sv
// Behavioural 16x2 single-port SRAM model standing in for the scn4m_subm macro.
// Commands are captured on the rising edge of clk0 and executed on the falling edge.
module sram_2_16_scn4m_subm #(
  parameter int DATA_WIDTH = 2,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_WORDS  = 2 ** ADDR_WIDTH
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0
);

  logic                  csb0_d;
  logic                  csb0_q;
  logic                  web0_d;
  logic                  web0_q;
  logic [ADDR_WIDTH-1:0] addr0_d;
  logic [ADDR_WIDTH-1:0] addr0_q;
  logic [DATA_WIDTH-1:0] din0_d;
  logic [DATA_WIDTH-1:0] din0_q;
  logic [DATA_WIDTH-1:0] dout0_d;
  logic [DATA_WIDTH-1:0] dout0_q;

  logic                  mem_we_s;
  logic [DATA_WIDTH-1:0] mem_wdata_s;

  // Storage array: deliberately no reset and no initial value.
  logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];

  always_comb begin
    csb0_d  = csb0;
    web0_d  = web0;
    addr0_d = addr0;
    din0_d  = din0;
  end

  // Reset parks the port deselected, which also cancels an access already captured.
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      csb0_q  <= 1'b1;
      web0_q  <= 1'b1;
      addr0_q <= {ADDR_WIDTH{1'b0}};
      din0_q  <= {DATA_WIDTH{1'b0}};
    end else begin
      csb0_q  <= csb0_d;
      web0_q  <= web0_d;
      addr0_q <= addr0_d;
      din0_q  <= din0_d;
    end
  end

  always_comb begin
    dout0_d     = dout0_q;
    mem_we_s    = 1'b0;
    mem_wdata_s = din0_q;
    if (!csb0_q) begin
      if (web0_q) begin
        dout0_d = mem_q[addr0_q];
      end else begin
        mem_we_s = 1'b1;
      end
    end else begin
      mem_we_s = 1'b0;
    end
`ifndef SYNTHESIS
    // An undecodable operation poisons both the output and the addressed word.
    if (!csb0_q && $isunknown(web0_q)) begin
      dout0_d     = {DATA_WIDTH{1'bx}};
      mem_we_s    = 1'b1;
      mem_wdata_s = {DATA_WIDTH{1'bx}};
    end else begin
      mem_wdata_s = mem_wdata_s;
    end
    // An unknown address can't name a word, so nothing is written.
    if (!csb0_q && $isunknown(addr0_q)) begin
      dout0_d  = {DATA_WIDTH{1'bx}};
      mem_we_s = 1'b0;
    end else begin
      mem_we_s = mem_we_s;
    end
`endif
  end

  always_ff @(negedge clk0) begin
    if (mem_we_s) begin
      mem_q[addr0_q] <= mem_wdata_s;
    end
  end

  always_ff @(negedge clk0 or posedge rst0) begin
    if (rst0) begin
      dout0_q <= {DATA_WIDTH{1'b0}};
    end else begin
      dout0_q <= dout0_d;
    end
  end

  assign dout0 = dout0_q;

endmodule

// File: tb/tb_sram_2_16_scn4m_subm.sv
// Directed bench for sram_2_16_scn4m_subm: a reference model predicts dout0 for
// every cycle, pushes it to a scoreboard and compares after the falling edge.
module tb_sram_2_16_scn4m_subm;

  logic       clk0;
  logic       rst0;
  logic       csb0;
  logic       web0;
  logic [3:0] addr0;
  logic [1:0] din0;
  logic [1:0] dout0;

  typedef struct {
    logic [1:0] val;
    bit         is_x;
    string      tag;
  } exp_t;

  exp_t       exp_q[$];
  logic [1:0] model_mem [16];
  bit         written [16];
  logic [1:0] m_val;
  bit         m_x;
  bit         four_state;
  logic [1:0] x_probe;
  int         errors;
  int         checks;

  sram_2_16_scn4m_subm dut (
    .clk0  (clk0),
    .rst0  (rst0),
    .csb0  (csb0),
    .web0  (web0),
    .addr0 (addr0),
    .din0  (din0),
    .dout0 (dout0)
  );

  initial begin
    clk0 = 1'b0;
    forever #5 clk0 = ~clk0;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input string tag);
    exp_t e;
    e.val  = m_val;
    e.is_x = m_x;
    e.tag  = tag;
    exp_q.push_back(e);
  endtask

  task automatic check_dout();
    exp_t e;
    e = exp_q.pop_front();
    checks++;
    if (e.is_x) begin
      // Only a four-state simulator can hold X; a two-state one cannot be checked here.
      assert ((dout0 === 2'bxx) || !four_state) else begin
        errors++;
        $error("FAIL %s: dout0=%b expected=xx", e.tag, dout0);
      end
    end else begin
      assert (dout0 === e.val) else begin
        errors++;
        $error("FAIL %s: dout0=%b expected=%b", e.tag, dout0, e.val);
      end
    end
  endtask

  // One full port cycle: drive, capture on posedge, check after negedge.
  task automatic op(input logic c, input logic w, input logic [3:0] a,
                    input logic [1:0] d, input string tag);
    csb0  = c;
    web0  = w;
    addr0 = a;
    din0  = d;
    if (!c) begin
      if (w) begin
        if (written[a]) begin
          m_val = model_mem[a];
          m_x   = 1'b0;
        end else begin
          m_x = 1'b1;
        end
      end else begin
        model_mem[a] = d;
        written[a]   = 1'b1;
      end
    end
    push_exp(tag);
    @(posedge clk0);
    @(negedge clk0);
    #1;
    check_dout();
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    x_probe = 2'bxx;
    four_state = (x_probe === 2'bxx);
    for (int i = 0; i < 16; i++) written[i] = 1'b0;

    rst0  = 1'b1;
    csb0  = 1'b1;
    web0  = 1'b1;
    addr0 = 4'h0;
    din0  = 2'b00;
    m_val = 2'b00;
    m_x   = 1'b0;
    @(negedge clk0);
    #1;
    push_exp("reset_state");
    check_dout();
    rst0 = 1'b0;

    op(1'b0, 1'b0, 4'h1, 2'b10, "write_1_hold");
    op(1'b0, 1'b0, 4'hC, 2'b01, "write_c_hold");
    op(1'b0, 1'b1, 4'h0, 2'b00, "read_0_unwritten");
    op(1'b0, 1'b1, 4'hC, 2'b00, "read_c");
    op(1'b0, 1'b0, 4'hA, 2'b11, "write_a_hold");
    op(1'b0, 1'b1, 4'h1, 2'b00, "read_1");
    op(1'b0, 1'b1, 4'hA, 2'b00, "read_a");
    op(1'b0, 1'b1, 4'h0, 2'b00, "read_0_no_alias");
    op(1'b0, 1'b1, 4'hC, 2'b00, "read_c_again");
    op(1'b0, 1'b0, 4'h5, 2'b11, "write_5_hold");
    op(1'b1, 1'b0, 4'h1, 2'b00, "deselect_write_hold");

    // Read of addr 5 captured, then reset lands before the falling edge.
    csb0  = 1'b0;
    web0  = 1'b1;
    addr0 = 4'h5;
    din0  = 2'b00;
    @(posedge clk0);
    #2;
    rst0  = 1'b1;
    #1;
    m_val = 2'b00;
    m_x   = 1'b0;
    push_exp("reset_async_clear");
    check_dout();
    @(negedge clk0);
    #1;
    push_exp("reset_read_suppressed");
    check_dout();
    rst0 = 1'b0;

    op(1'b0, 1'b1, 4'h5, 2'b00, "read_5_after_reset");
    op(1'b1, 1'b1, 4'h3, 2'b00, "deselect_hold_a");
    op(1'b1, 1'b0, 4'h5, 2'b00, "deselect_hold_b");
    op(1'b0, 1'b1, 4'h1, 2'b00, "read_1_not_overwritten");
    op(1'b0, 1'b0, 4'h3, 2'b10, "raw_write_3a");
    op(1'b0, 1'b1, 4'h3, 2'b00, "raw_read_3a");
    op(1'b0, 1'b0, 4'h3, 2'b01, "raw_write_3b");
    op(1'b0, 1'b1, 4'h3, 2'b00, "raw_read_3b");

    for (int i = 0; i < 16; i++) begin
      op(1'b0, 1'b0, 4'(i), 2'((i * 3 + 1) % 4), "sweep_write");
    end
    for (int i = 15; i >= 0; i--) begin
      op(1'b0, 1'b1, 4'(i), 2'b00, "sweep_read");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
